// File: rtl/mux_scan_pkg.sv
// Shared types, defaults and helpers for the mux_scan channel selector.
// Imported by the top and by the dwell timer.
package mux_scan_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_NCH   = 4;
  localparam int DEF_SELW  = 2;
  localparam int DEF_DWELL = 16;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_SCAN   = 2'd1,
    MODE_HOLD   = 2'd2
  } mode_e;

  // ceil(log2(n)), never less than 1 so a DWELL=1 counter still has a bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // hold only has meaning while scanning
  function automatic mode_e mode_decode(input logic scan_en, input logic hold);
    if (!scan_en) return MODE_MANUAL;
    return hold ? MODE_HOLD : MODE_SCAN;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while run is high and
// flags the terminal count so the channel index can step.
module dwell_timer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = DEF_DWELL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int              CW      = clog2_min1(DWELL);
  localparam logic [CW-1:0]   LP_TERM = CW'(DWELL - 1);

  logic [CW-1:0] r_count;
  logic          w_at_term;

  assign w_at_term = (r_count == LP_TERM);
  assign tick      = run && w_at_term;

  // clr wins over run so manual mode always parks the count at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= w_at_term ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/mux_scan.sv
// Registered N:1 channel selector with manual select and round-robin scan.
// ch and dout load on the same edge, so dout always reflects din[ch].
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int SELW  = DEF_SELW,
  parameter int DWELL = DEF_DWELL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SELW-1:0]      sel,
  input  logic                 scan_en,
  input  logic                 hold,
  output logic [WIDTH-1:0]     dout,
  output logic [SELW-1:0]      ch,
  output logic                 ch_adv,
  output logic                 wrap
);

  localparam int              NSLOT   = 1 << SELW;
  localparam logic [SELW-1:0] LP_LAST = SELW'(NCH - 1);

  mode_e            w_mode;
  logic             w_run;
  logic             w_clr;
  logic             w_tick;
  logic [SELW-1:0]  w_ch_nxt;
  logic             w_adv_nxt;
  logic             w_wrap_nxt;
  logic [WIDTH-1:0] w_chan [NSLOT];

  logic [SELW-1:0]  r_ch;
  logic [WIDTH-1:0] r_dout;
  logic             r_ch_adv;
  logic             r_wrap;

  // Pad the channel table to the full select range so every index is defined
  for (genvar k = 0; k < NSLOT; k++) begin : g_chan
    if (k < NCH) begin : g_real
      assign w_chan[k] = din[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_chan[k] = '0;
    end
  end

  assign w_mode = mode_decode(scan_en, hold);
  assign w_run  = (w_mode == MODE_SCAN);
  assign w_clr  = (w_mode == MODE_MANUAL);

  dwell_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_run),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_comb begin
    w_ch_nxt   = r_ch;
    w_adv_nxt  = 1'b0;
    w_wrap_nxt = 1'b0;
    unique case (w_mode)
      MODE_MANUAL: begin
        // out-of-range selects are ignored, the current channel is kept
        if (sel <= LP_LAST) w_ch_nxt = sel;
      end
      MODE_SCAN: begin
        if (w_tick) begin
          w_adv_nxt = 1'b1;
          if (r_ch == LP_LAST) begin
            w_ch_nxt   = '0;
            w_wrap_nxt = 1'b1;
          end else begin
            w_ch_nxt = r_ch + SELW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch     <= '0;
      r_dout   <= '0;
      r_ch_adv <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_ch     <= w_ch_nxt;
      r_dout   <= w_chan[w_ch_nxt];
      r_ch_adv <= w_adv_nxt;
      r_wrap   <= w_wrap_nxt;
    end
  end

  assign ch     = r_ch;
  assign dout   = r_dout;
  assign ch_adv = r_ch_adv;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: directed scenarios plus random traffic against a
// behavioural model, on three configurations (4ch/D3, 3ch/D3, 4ch/D1).
module tb_mux_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din4;
  logic [11:0] din3;
  logic [1:0]  sel;
  logic        scan_en;
  logic        hold;

  logic [3:0] dout_a, dout_b, dout_c;
  logic [1:0] ch_a, ch_b, ch_c;
  logic       adv_a, adv_b, adv_c;
  logic       wrap_a, wrap_b, wrap_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mux_scan #(.WIDTH(4), .NCH(4), .SELW(2), .DWELL(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .din(din4), .sel(sel), .scan_en(scan_en), .hold(hold),
    .dout(dout_a), .ch(ch_a), .ch_adv(adv_a), .wrap(wrap_a));

  mux_scan #(.WIDTH(4), .NCH(3), .SELW(2), .DWELL(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel), .scan_en(scan_en), .hold(hold),
    .dout(dout_b), .ch(ch_b), .ch_adv(adv_b), .wrap(wrap_b));

  mux_scan #(.WIDTH(4), .NCH(4), .SELW(2), .DWELL(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .din(din4), .sel(sel), .scan_en(scan_en), .hold(hold),
    .dout(dout_c), .ch(ch_c), .ch_adv(adv_c), .wrap(wrap_c));

  logic [3:0] a_dout [3];
  logic [1:0] a_ch   [3];
  logic       a_adv  [3];
  logic       a_wrap [3];
  assign a_dout[0] = dout_a; assign a_ch[0] = ch_a; assign a_adv[0] = adv_a; assign a_wrap[0] = wrap_a;
  assign a_dout[1] = dout_b; assign a_ch[1] = ch_b; assign a_adv[1] = adv_b; assign a_wrap[1] = wrap_b;
  assign a_dout[2] = dout_c; assign a_ch[2] = ch_c; assign a_adv[2] = adv_c; assign a_wrap[2] = wrap_c;

  // Reference model: channel index and dwell position as plain integers
  logic [1:0] m_ch   [3];
  int         m_cnt  [3];
  logic       m_adv  [3];
  logic       m_wrap [3];
  logic [3:0] m_dout [3];

  function automatic logic [3:0] chan(input int i, input int k);
    if (i == 1) return din3[k*4 +: 4];
    return din4[k*4 +: 4];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_ch[i] <= 2'd0; m_cnt[i] <= 0; m_adv[i] <= 1'b0; m_wrap[i] <= 1'b0; m_dout[i] <= 4'h0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin : g_m
        int nch, dw, c, n;
        logic a, w;
        nch = (i == 1) ? 3 : 4;
        dw  = (i == 2) ? 1 : 3;
        c = int'(m_ch[i]);
        n = m_cnt[i];
        a = 1'b0;
        w = 1'b0;
        if (!scan_en) begin
          if (int'(sel) < nch) c = int'(sel);
          n = 0;
        end else if (!hold) begin
          if (n == dw - 1) begin
            n = 0;
            a = 1'b1;
            w = (c == nch - 1);
            c = (c + 1) % nch;
          end else begin
            n = n + 1;
          end
        end
        m_ch[i]   <= 2'(c);
        m_cnt[i]  <= n;
        m_adv[i]  <= a;
        m_wrap[i] <= w;
        m_dout[i] <= chan(i, c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    din4 = {4'hD, 4'hC, 4'hB, 4'hA};
    din3 = {4'hC, 4'hB, 4'hA};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scan_en = 1'b0; hold = 1'b0; sel = 2'd0;
    set_defaults();
    step(); step();
    rst_n = 1'b1;
    sel = 2'd2;
    step();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (a_dout[i] !== 4'h0 || a_ch[i] !== 2'd0 || a_adv[i] !== 1'b0 || a_wrap[i] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_async inst%0d: dout=%h ch=%0d adv=%b wrap=%b, want all 0",
                 i, a_dout[i], a_ch[i], a_adv[i], a_wrap[i]);
      end
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_manual();
    scan_en = 1'b0; sel = 2'd2;
    step();
    n_checks++;
    if (ch_a !== 2'd2 || dout_a !== 4'hC) begin
      n_errors++;
      $display("FAIL manual_sel2: ch=%0d dout=%h, want ch=2 dout=C", ch_a, dout_a);
    end
    sel = 2'd3;
    step();
    n_checks++;
    if (ch_a !== 2'd3 || dout_a !== 4'hD) begin
      n_errors++;
      $display("FAIL manual_sel3: ch=%0d dout=%h, want ch=3 dout=D", ch_a, dout_a);
    end
    n_checks++;
    if (ch_b !== 2'd2 || dout_b !== 4'hC) begin
      n_errors++;
      $display("FAIL manual_illegal_3ch: ch=%0d dout=%h, want ch=2 dout=C", ch_b, dout_b);
    end
    din4[15:12] = 4'h5;
    step();
    n_checks++;
    if (dout_a !== 4'h5 || adv_a !== 1'b0) begin
      n_errors++;
      $display("FAIL manual_din_follow: dout=%h adv=%b, want dout=5 adv=0", dout_a, adv_a);
    end
    set_defaults();
  endtask

  task automatic test_scan();
    scan_en = 1'b0; sel = 2'd0;
    step();
    scan_en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      int ea, eb;
      step();
      ea = (k / 3) % 4;
      eb = (k / 3) % 3;
      n_checks++;
      if (ch_a !== 2'(ea) || dout_a !== 4'(4'hA + ea) || adv_a !== (k % 3 == 0) ||
          wrap_a !== (k % 3 == 0 && ea == 0)) begin
        n_errors++;
        $display("FAIL scan_d3 k=%0d: ch=%0d dout=%h adv=%b wrap=%b, want ch=%0d dout=%h adv=%b wrap=%b",
                 k, ch_a, dout_a, adv_a, wrap_a, ea, 4'(4'hA + ea), (k % 3 == 0), (k % 3 == 0 && ea == 0));
      end
      n_checks++;
      if (ch_b !== 2'(eb) || wrap_b !== (k % 3 == 0 && eb == 0)) begin
        n_errors++;
        $display("FAIL scan_3ch k=%0d: ch=%0d wrap=%b, want ch=%0d wrap=%b",
                 k, ch_b, wrap_b, eb, (k % 3 == 0 && eb == 0));
      end
      n_checks++;
      if (ch_c !== 2'(k % 4) || adv_c !== 1'b1 || wrap_c !== (k % 4 == 0)) begin
        n_errors++;
        $display("FAIL scan_dwell1 k=%0d: ch=%0d adv=%b wrap=%b, want ch=%0d adv=1 wrap=%b",
                 k, ch_c, adv_c, wrap_c, k % 4, (k % 4 == 0));
      end
    end
  endtask

  task automatic test_hold();
    scan_en = 1'b0; sel = 2'd0; hold = 1'b0;
    step();
    scan_en = 1'b1;
    repeat (4) step();
    n_checks++;
    if (ch_a !== 2'd1) begin
      n_errors++;
      $display("FAIL hold_pre: ch=%0d, want 1", ch_a);
    end
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (ch_a !== 2'd1 || dout_a !== 4'hB || adv_a !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_frozen k=%0d: ch=%0d dout=%h adv=%b, want ch=1 dout=B adv=0",
                 k, ch_a, dout_a, adv_a);
      end
    end
    hold = 1'b0;
    step();
    n_checks++;
    if (ch_a !== 2'd1 || adv_a !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_release1: ch=%0d adv=%b, want ch=1 adv=0", ch_a, adv_a);
    end
    step();
    n_checks++;
    if (ch_a !== 2'd2 || adv_a !== 1'b1 || dout_a !== 4'hC) begin
      n_errors++;
      $display("FAIL hold_release2: ch=%0d adv=%b dout=%h, want ch=2 adv=1 dout=C", ch_a, adv_a, dout_a);
    end
  endtask

  task automatic test_illegal_select();
    scan_en = 1'b0; hold = 1'b0; sel = 2'd1;
    step();
    sel = 2'd3;
    step();
    n_checks++;
    if (ch_b !== 2'd1 || dout_b !== 4'hB) begin
      n_errors++;
      $display("FAIL illegal_sel: ch=%0d dout=%h, want ch=1 dout=B", ch_b, dout_b);
    end
    scan_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      int eb;
      step();
      eb = (1 + k / 3) % 3;
      n_checks++;
      if (ch_b !== 2'(eb) || wrap_b !== (k == 6)) begin
        n_errors++;
        $display("FAIL illegal_wrap k=%0d: ch=%0d wrap=%b, want ch=%0d wrap=%b", k, ch_b, wrap_b, eb, (k == 6));
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    scan_en = 1'b0; hold = 1'b0; sel = 2'd0;
    step();
    scan_en = 1'b1;
    repeat (7) step();
    n_checks++;
    if (ch_a !== 2'd2) begin
      n_errors++;
      $display("FAIL midscan_pre: ch=%0d, want 2", ch_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ch_a !== 2'd0 || dout_a !== 4'h0 || adv_a !== 1'b0 || wrap_a !== 1'b0) begin
      n_errors++;
      $display("FAIL midscan_reset: ch=%0d dout=%h adv=%b wrap=%b, want all 0", ch_a, dout_a, adv_a, wrap_a);
    end
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_checks++;
      if (ch_a !== 2'(k / 3) || adv_a !== (k == 3)) begin
        n_errors++;
        $display("FAIL midscan_restart k=%0d: ch=%0d adv=%b, want ch=%0d adv=%b", k, ch_a, adv_a, k / 3, (k == 3));
      end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 300; cyc++) begin
      din4    = 16'($urandom);
      din3    = 12'($urandom);
      sel     = 2'($urandom_range(0, 3));
      scan_en = ($urandom_range(0, 7) != 0);
      hold    = ($urandom_range(0, 3) == 0);
      if (cyc % 89 == 40) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (a_dout[i] !== m_dout[i] || a_ch[i] !== m_ch[i] || a_adv[i] !== m_adv[i] || a_wrap[i] !== m_wrap[i]) begin
          n_errors++;
          $display("FAIL random cyc=%0d inst%0d: dout=%h ch=%0d adv=%b wrap=%b, want dout=%h ch=%0d adv=%b wrap=%b",
                   cyc, i, a_dout[i], a_ch[i], a_adv[i], a_wrap[i], m_dout[i], m_ch[i], m_adv[i], m_wrap[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_hold();
    test_illegal_select();
    test_reset_mid_scan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
